st_vip_packetizer: RTL and testbench



---
 rtl/st_vip_packetizer_pkg.sv | 20 ++
 rtl/st_vip_packetizer_if.sv | 39 +++
 rtl/st_vip_packetizer_expand.sv | 21 ++
 rtl/st_vip_packetizer.sv | 166 ++++++++++++++++
 tb/tb_st_vip_packetizer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/st_vip_packetizer_pkg.sv
// Shared types and constants for the Avalon-ST to VIP packetizer.
package st_vip_pkg;
    typedef enum logic [2:0] {
        IDLE,
        CTRL_ID,
        CTRL_DATA,
        VID_ID,
        DATA,
        DRAIN
    } state_t;

    localparam logic [3:0] VIP_CTRL_ID  = 4'hF;
    localparam logic [3:0] VIP_VIDEO_ID = 4'h0;
    localparam int         CTRL_NIBBLES = 9;

    // Number of beats needed to carry the nine control nibbles.
    function automatic int ctrl_beats(input int s);
        return (CTRL_NIBBLES + s - 1) / s;
    endfunction
endpackage

// File: rtl/st_vip_packetizer_if.sv
// Config, sink, source and status bundle for st_vip_packetizer.
interface st_vip_packetizer_if #(
    parameter int DATA_WIDTH = 24
);
    logic [15:0]           cfg_width;
    logic [15:0]           cfg_height;
    logic [3:0]            cfg_interlace;
    logic [15:0]           din_data;
    logic                  din_valid;
    logic                  din_startofpacket;
    logic                  din_endofpacket;
    logic                  din_ready;
    logic [DATA_WIDTH-1:0] dout_data;
    logic                  dout_valid;
    logic                  dout_startofpacket;
    logic                  dout_endofpacket;
    logic                  dout_ready;
    logic                  frame_done;
    logic                  short_frame;
    logic                  long_frame;

    modport master (
        output cfg_width, cfg_height, cfg_interlace,
        output din_data, din_valid, din_startofpacket, din_endofpacket,
        input  din_ready,
        input  dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
        output dout_ready,
        input  frame_done, short_frame, long_frame
    );

    modport slave (
        input  cfg_width, cfg_height, cfg_interlace,
        input  din_data, din_valid, din_startofpacket, din_endofpacket,
        output din_ready,
        output dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
        input  dout_ready,
        output frame_done, short_frame, long_frame
    );
endinterface

// File: rtl/st_vip_packetizer_expand.sv
// RGB565 to BITS_PER_SYMBOL-per-channel expansion by repeating each channel's MSBs.
module rgb565_expand #(
    parameter int BITS_PER_SYMBOL = 8
) (
    input  logic [15:0]                rgb,
    output logic [BITS_PER_SYMBOL-1:0] r,
    output logic [BITS_PER_SYMBOL-1:0] g,
    output logic [BITS_PER_SYMBOL-1:0] b
);
    // Cycling through the source bits MSB-first gives {x, x[msb..]} for any width.
    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        for (int i = 0; i < BITS_PER_SYMBOL; i++) begin
            r[BITS_PER_SYMBOL-1-i] = rgb[15 - (i % 5)];
            g[BITS_PER_SYMBOL-1-i] = rgb[10 - (i % 6)];
            b[BITS_PER_SYMBOL-1-i] = rgb[4 - (i % 5)];
        end
    end
endmodule

// File: rtl/st_vip_packetizer.sv
// Wraps each RGB565 frame as a VIP control packet plus video packet, repairing
// frames whose pixel count disagrees with the configured width*height.
module st_vip_packetizer
    import st_vip_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int DATA_WIDTH       = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
    input logic                clk,
    input logic                rst_n,
    st_vip_packetizer_if.slave bus
);
    localparam int         N_CTRL    = ctrl_beats(SYMBOLS_PER_BEAT);
    localparam logic [3:0] LAST_BEAT = 4'(N_CTRL - 1);

    state_t                state, state_d;
    logic [3:0]            beat_cnt;
    logic [31:0]           pix_cnt, pix_inc, total;
    logic [15:0]           width_q, height_q;
    logic [3:0]            ilace_q;
    logic [3:0]            nib [CTRL_NIBBLES];
    logic [DATA_WIDTH-1:0] ctrl_word, pix_word, dout_data;
    logic                  din_rdy, dout_vld, dout_sop, dout_eop, at_total;
    logic                  frame_done_d, short_d, long_d;
    logic                  frame_done_q, short_q, long_q;

    generate
        if (SYMBOLS_PER_BEAT == 3) begin : g_rgb
            logic [BITS_PER_SYMBOL-1:0] r, g, b;
            rgb565_expand #(.BITS_PER_SYMBOL(BITS_PER_SYMBOL)) u_expand (
                .rgb(bus.din_data), .r(r), .g(g), .b(b)
            );
            assign pix_word = {r, g, b};
        end else begin : g_raw
            always_comb begin
                pix_word = '0;
                for (int i = 0; i < DATA_WIDTH && i < 16; i++) pix_word[i] = bus.din_data[i];
            end
        end
    endgenerate

    assign nib[0] = width_q[15:12];
    assign nib[1] = width_q[11:8];
    assign nib[2] = width_q[7:4];
    assign nib[3] = width_q[3:0];
    assign nib[4] = height_q[15:12];
    assign nib[5] = height_q[11:8];
    assign nib[6] = height_q[7:4];
    assign nib[7] = height_q[3:0];
    assign nib[8] = ilace_q;

    // Nibble k lands in the low bits of symbol k%S on beat k/S.
    always_comb begin
        ctrl_word = '0;
        for (int k = 0; k < CTRL_NIBBLES; k++) begin
            if (k / SYMBOLS_PER_BEAT == int'(beat_cnt))
                ctrl_word[(k % SYMBOLS_PER_BEAT)*BITS_PER_SYMBOL +: 4] = nib[k];
        end
    end

    assign pix_inc  = pix_cnt + 32'd1;
    assign at_total = (total != 32'd0) && (pix_inc == total);

    always_comb begin
        state_d      = state;
        din_rdy      = 1'b0;
        dout_vld     = 1'b0;
        dout_sop     = 1'b0;
        dout_eop     = 1'b0;
        dout_data    = '0;
        frame_done_d = 1'b0;
        short_d      = 1'b0;
        long_d       = 1'b0;
        unique case (state)
            IDLE: begin
                // Stray beats before a SOP are swallowed; the SOP pixel waits for DATA.
                if (bus.din_valid) begin
                    if (bus.din_startofpacket) state_d = CTRL_ID;
                    else                       din_rdy = 1'b1;
                end
            end
            CTRL_ID: begin
                dout_vld       = 1'b1;
                dout_sop       = 1'b1;
                dout_data[3:0] = VIP_CTRL_ID;
                if (bus.dout_ready) state_d = CTRL_DATA;
            end
            CTRL_DATA: begin
                dout_vld  = 1'b1;
                dout_data = ctrl_word;
                dout_eop  = (beat_cnt == LAST_BEAT);
                if (bus.dout_ready && beat_cnt == LAST_BEAT) state_d = VID_ID;
            end
            VID_ID: begin
                dout_vld       = 1'b1;
                dout_sop       = 1'b1;
                dout_data[3:0] = VIP_VIDEO_ID;
                if (bus.dout_ready) state_d = DATA;
            end
            DATA: begin
                dout_vld  = bus.din_valid;
                din_rdy   = bus.dout_ready;
                dout_data = pix_word;
                dout_eop  = bus.din_valid & (bus.din_endofpacket | at_total);
                if (bus.din_valid && bus.dout_ready) begin
                    if (bus.din_endofpacket) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        short_d      = (pix_inc < total);
                    end else if (at_total) begin
                        state_d      = DRAIN;
                        frame_done_d = 1'b1;
                        long_d       = 1'b1;
                    end
                end
            end
            DRAIN: begin
                din_rdy = 1'b1;
                if (bus.din_valid && bus.din_endofpacket) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            pix_cnt      <= '0;
            total        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            ilace_q      <= '0;
            frame_done_q <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            state        <= state_d;
            frame_done_q <= frame_done_d;
            short_q      <= short_d;
            long_q       <= long_d;
            if (state == IDLE && bus.din_valid && bus.din_startofpacket) begin
                width_q  <= bus.cfg_width;
                height_q <= bus.cfg_height;
                ilace_q  <= bus.cfg_interlace;
            end
            if (state == CTRL_ID) begin
                total    <= 32'(width_q) * 32'(height_q);
                pix_cnt  <= '0;
                beat_cnt <= '0;
            end
            if (state == CTRL_DATA && bus.dout_ready) beat_cnt <= beat_cnt + 4'd1;
            if (state == DATA && bus.din_valid && bus.dout_ready) pix_cnt <= pix_inc;
        end
    end

    assign bus.din_ready          = din_rdy;
    assign bus.dout_valid         = dout_vld;
    assign bus.dout_startofpacket = dout_sop;
    assign bus.dout_endofpacket   = dout_eop;
    assign bus.dout_data          = dout_data;
    assign bus.frame_done         = frame_done_q;
    assign bus.short_frame        = short_q;
    assign bus.long_frame         = long_q;
endmodule

// File: tb/tb_st_vip_packetizer.sv
// Bench for st_vip_packetizer: frames checked against a beat-list model built from the packet rules.
module tb_st_vip_packetizer;
    localparam int B = 8;

    typedef struct packed {
        logic [23:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    st_vip_packetizer_if #(.DATA_WIDTH(3*B)) vif ();
    st_vip_packetizer_if #(.DATA_WIDTH(B))   vif1 ();

    st_vip_packetizer #(.BITS_PER_SYMBOL(B), .SYMBOLS_PER_BEAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(vif)
    );
    st_vip_packetizer #(.BITS_PER_SYMBOL(B), .SYMBOLS_PER_BEAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(vif1)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    beat_t       got[$], got1[$], exp_q[$];
    logic [15:0] pix_q[$];
    int          exp_sf, exp_lf;
    int          fd_cnt = 0, sf_cnt = 0, lf_cnt = 0, stall_err = 0;
    logic        stall_prev = 1'b0;
    logic [24:0] stall_snap = '0;

    initial begin
        vif.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            vif.dout_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    always @(negedge clk) begin
        if (vif.dout_valid && vif.dout_ready)
            got.push_back('{vif.dout_data, vif.dout_startofpacket, vif.dout_endofpacket});
        if (vif1.dout_valid && vif1.dout_ready)
            got1.push_back('{24'(vif1.dout_data), vif1.dout_startofpacket, vif1.dout_endofpacket});
        fd_cnt <= fd_cnt + int'(vif.frame_done);
        sf_cnt <= sf_cnt + int'(vif.short_frame);
        lf_cnt <= lf_cnt + int'(vif.long_frame);
        if (stall_prev && rst_n && (!vif.dout_valid || {vif.dout_data, vif.dout_endofpacket} !== stall_snap))
            stall_err <= stall_err + 1;
        stall_prev <= rst_n && vif.dout_valid && !vif.dout_ready;
        stall_snap <= {vif.dout_data, vif.dout_endofpacket};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish within 100000 cycles");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] exp_rgb(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = (r << 3) | (r >> 2);
        g = (g << 2) | (g >> 4);
        b = (b << 3) | (b >> 2);
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    // Reference beat list: control packet, video header, then pixels clipped to w*h.
    task automatic build_exp(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                             input int s, input int n_in);
        logic [3:0]  nib [9];
        logic [23:0] d;
        int          nbeats, n_out;
        longint      tot;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            nib[k]     = 4'(w >> (12 - 4*k));
            nib[4 + k] = 4'(h >> (12 - 4*k));
        end
        nib[8] = il;
        exp_q.push_back('{24'hF, 1'b1, 1'b0});
        nbeats = (9 + s - 1) / s;
        for (int j = 0; j < nbeats; j++) begin
            d = '0;
            for (int k = j*s; k < 9 && k < (j+1)*s; k++) d = d | (24'(nib[k]) << (8*(k - j*s)));
            exp_q.push_back('{d, 1'b0, j == nbeats - 1});
        end
        exp_q.push_back('{24'h0, 1'b1, 1'b0});
        tot   = longint'(w) * longint'(h);
        n_out = (tot != 0 && n_in > tot) ? int'(tot) : n_in;
        for (int i = 0; i < n_out; i++)
            exp_q.push_back('{(s == 3) ? exp_rgb(pix_q[i]) : 24'(pix_q[i][7:0]), 1'b0, i == n_out - 1});
        exp_sf = (tot != 0 && n_in < tot) ? 1 : 0;
        exp_lf = (tot != 0 && n_in > tot) ? 1 : 0;
    endtask

    task automatic drive_beat(input logic [15:0] d, input bit sop, input bit eop, input bit gaps);
        bit done;
        if (gaps && $urandom_range(0, 2) == 0) begin
            vif.din_valid = 1'b0;
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
        vif.din_valid         = 1'b1;
        vif.din_data          = d;
        vif.din_startofpacket = sop;
        vif.din_endofpacket   = eop;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            done = vif.din_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL din_handshake got din_ready=0 want din_ready=1 within 300 cycles");
        end
    endtask

    task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                             input int n_in, input int mid_sop, input bit gaps);
        vif.cfg_width     = w;
        vif.cfg_height    = h;
        vif.cfg_interlace = il;
        for (int i = 0; i < n_in; i++) begin
            drive_beat(pix_q[i], (i == 0) || (i == mid_sop), i == n_in - 1, gaps);
            if (i == 0) begin
                vif.cfg_width     = 16'($urandom);
                vif.cfg_height    = 16'($urandom);
                vif.cfg_interlace = 4'($urandom);
            end
        end
        vif.din_valid         = 1'b0;
        vif.din_startofpacket = 1'b0;
        vif.din_endofpacket   = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        build_exp(w, h, il, 3, n_in);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({vif.din_ready, vif.dout_valid, vif.dout_startofpacket, vif.dout_endofpacket,
             vif.frame_done, vif.short_frame, vif.long_frame} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0000000", {vif.din_ready, vif.dout_valid,
                     vif.dout_startofpacket, vif.dout_endofpacket, vif.frame_done,
                     vif.short_frame, vif.long_frame});
        end
        n_tests++;
        if (vif.dout_data !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 000000", vif.dout_data);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int fd0, sf0, lf0;
        ready_mode = 1;
        got.delete();
        drive_beat(16'h1111, 1'b0, 1'b0, 1'b0);
        drive_beat(16'h2222, 1'b0, 1'b1, 1'b0);
        vif.din_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_tests++;
        if (got.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_drop got %0d beats want 0", got.size());
        end
        fd0 = fd_cnt; sf0 = sf_cnt; lf0 = lf_cnt;
        pix_q = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000, 16'h1234, 16'h8410, 16'hABCD};
        run_frame(16'd4, 16'd2, 4'h2, 8, 3, 1'b0);
        n_tests++;
        if (got.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_beat%0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_tests++;
        if (got.size() > 6 && {got[5].d, got[6].d} !== {24'hFF0000, 24'h00FF00}) begin
            n_fail++;
            $display("FAIL basic_primaries got %h %h want ff0000 00ff00", got[5].d, got[6].d);
        end
        n_tests++;
        if ({fd_cnt - fd0, sf_cnt - sf0, lf_cnt - lf0} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL basic_pulses got fd=%0d sf=%0d lf=%0d want 1 0 0",
                     fd_cnt - fd0, sf_cnt - sf0, lf_cnt - lf0);
        end
    endtask

    task automatic test_size_repair;
        int fd0, sf0, lf0, n_in;
        ready_mode = 1;
        for (int c = 0; c < 2; c++) begin
            n_in = (c == 0) ? 5 : 12;
            got.delete();
            pix_q.delete();
            for (int i = 0; i < n_in; i++) pix_q.push_back(16'($urandom));
            fd0 = fd_cnt; sf0 = sf_cnt; lf0 = lf_cnt;
            run_frame(16'd4, 16'd2, 4'h0, n_in, -1, 1'b0);
            n_tests++;
            if (got.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL repair%0d_count got %0d want %0d", n_in, got.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                n_tests++;
                if (got[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL repair%0d_beat%0d got %h want %h", n_in, i, got[i], exp_q[i]);
                end
            end
            n_tests++;
            if (fd_cnt - fd0 !== 1 || sf_cnt - sf0 !== exp_sf || lf_cnt - lf0 !== exp_lf) begin
                n_fail++;
                $display("FAIL repair%0d_pulses got fd=%0d sf=%0d lf=%0d want 1 %0d %0d", n_in,
                         fd_cnt - fd0, sf_cnt - sf0, lf_cnt - lf0, exp_sf, exp_lf);
            end
        end
    endtask

    task automatic test_reset_mid;
        ready_mode = 1;
        got.delete();
        vif.cfg_width         = 16'd4;
        vif.cfg_height        = 16'd2;
        vif.cfg_interlace     = 4'h2;
        vif.din_data          = 16'hF800;
        vif.din_valid         = 1'b1;
        vif.din_startofpacket = 1'b1;
        vif.din_endofpacket   = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        @(negedge clk);
        ready_mode = 0;
        @(posedge clk);
        #2;
        n_tests++;
        if (got.size() !== 2 || vif.dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup got %0d beats valid=%b want 2 beats valid=1", got.size(), vif.dout_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({vif.din_ready, vif.dout_valid, vif.dout_startofpacket, vif.dout_endofpacket,
             vif.frame_done, vif.short_frame, vif.long_frame, vif.dout_data} !== 31'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs got %b_%h want all zero", {vif.din_ready, vif.dout_valid,
                     vif.dout_startofpacket, vif.dout_endofpacket}, vif.dout_data);
        end
        rst_n         = 1'b1;
        ready_mode    = 1;
        vif.din_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        got.delete();
        pix_q = '{16'h07E0, 16'h001F, 16'hF81F};
        run_frame(16'd3, 16'd1, 4'h5, 3, -1, 1'b0);
        n_tests++;
        if (got.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL midrst_count got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midrst_beat%0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        int fd0, sf0, lf0, st0, n_in;
        logic [15:0] w, h;
        ready_mode = 2;
        st0 = stall_err;
        for (int f = 0; f < 8; f++) begin
            w = 16'($urandom_range(1, 4));
            h = 16'($urandom_range(0, 3));
            n_in = (h == 0) ? $urandom_range(1, 6) : $urandom_range(1, int'(w*h) + 3);
            got.delete();
            pix_q.delete();
            for (int i = 0; i < n_in; i++) pix_q.push_back(16'($urandom));
            fd0 = fd_cnt; sf0 = sf_cnt; lf0 = lf_cnt;
            run_frame(w, h, 4'($urandom), n_in, -1, 1'b1);
            repeat (4) begin @(posedge clk); #1; end
            n_tests++;
            if (got.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count got %0d want %0d", f, got.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                n_tests++;
                if (got[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d got %h want %h", f, i, got[i], exp_q[i]);
                end
            end
            n_tests++;
            if (fd_cnt - fd0 !== 1 || sf_cnt - sf0 !== exp_sf || lf_cnt - lf0 !== exp_lf) begin
                n_fail++;
                $display("FAIL rand%0d_pulses got fd=%0d sf=%0d lf=%0d want 1 %0d %0d", f,
                         fd_cnt - fd0, sf_cnt - sf0, lf_cnt - lf0, exp_sf, exp_lf);
            end
        end
        n_tests++;
        if (stall_err - st0 !== 0) begin
            n_fail++;
            $display("FAIL rand_stall_stable got %0d unstable stalls want 0", stall_err - st0);
        end
        ready_mode = 1;
    endtask

    task automatic test_s1;
        bit done;
        got1.delete();
        pix_q = '{16'hA5C3, 16'h1234, 16'hFF7E};
        vif1.cfg_width         = 16'd4;
        vif1.cfg_height        = 16'd2;
        vif1.cfg_interlace     = 4'h2;
        vif1.din_data          = pix_q[0];
        vif1.din_valid         = 1'b1;
        vif1.din_startofpacket = 1'b1;
        vif1.din_endofpacket   = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            done = vif1.din_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL s1_handshake got din_ready=0 want din_ready=1 within 100 cycles");
        end
        for (int i = 1; i < 3; i++) begin
            vif1.din_data          = pix_q[i];
            vif1.din_startofpacket = 1'b0;
            vif1.din_endofpacket   = (i == 2);
            @(posedge clk);
            #1;
        end
        vif1.din_valid       = 1'b0;
        vif1.din_endofpacket = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        build_exp(16'd4, 16'd2, 4'h2, 1, 3);
        n_tests++;
        if (got1.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL s1_count got %0d want %0d", got1.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
            n_tests++;
            if (got1[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL s1_beat%0d got %h want %h", i, got1[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        vif.cfg_width          = '0;
        vif.cfg_height         = '0;
        vif.cfg_interlace      = '0;
        vif.din_data           = '0;
        vif.din_valid          = 1'b0;
        vif.din_startofpacket  = 1'b0;
        vif.din_endofpacket    = 1'b0;
        vif1.cfg_width         = '0;
        vif1.cfg_height        = '0;
        vif1.cfg_interlace     = '0;
        vif1.din_data          = '0;
        vif1.din_valid         = 1'b0;
        vif1.din_startofpacket = 1'b0;
        vif1.din_endofpacket   = 1'b0;
        vif1.dout_ready        = 1'b1;
        test_reset();
        test_basic();
        test_size_repair();
        test_reset_mid();
        test_random();
        test_s1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
